// File: rtl/fc_egress_port.sv
// fc_egress_port: round-robin egress of a fully-connected NoC into one PE, with a delivery FIFO and misroute drop counter.
// Define FC_EGRESS_LATENCY_EN to add a free-running cycle counter and the o_latency output.
module fc_egress_port #(
  parameter int address = 0,
  parameter int AddressWidth = 3,
  parameter int numPE = 8,
  parameter int FifoDepth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [numPE*38-1:0]   i_data,
  input  logic [numPE-1:0]      i_data_valid,
  output logic [numPE-1:0]      o_data_ready,
  output logic [37:0]           o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
`ifdef FC_EGRESS_LATENCY_EN
  output logic [31:0]           o_latency,
`endif
  output logic [15:0]           o_drop_count
);
  localparam int RW = numPE > 1 ? $clog2(numPE) : 1;
  localparam int PW = $clog2(FifoDepth);
  localparam logic [AddressWidth-1:0] ADDR = AddressWidth'(address);
  logic [RW-1:0] rr, win;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [37:0] mem [FifoDepth];
  logic [37:0] flit;
  logic found, space_ok, pop, accept, push;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < numPE; i++)
      if (!found && i_data_valid[(int'(rr) + i) % numPE]) begin
        found = 1'b1;
        win = RW'((int'(rr) + i) % numPE);
      end
  end
  assign o_data_valid = count != '0;
  assign pop = o_data_valid & i_data_ready;
  assign space_ok = (count < (PW+1)'(FifoDepth)) | pop;
  // rst gating keeps ready low for the whole reset window, not just after the next edge
  assign accept = found & space_ok & ~rst;
  assign o_data_ready = accept ? numPE'(1) << win : '0;
  assign flit = i_data[int'(win)*38 +: 38];
  assign push = accept & (flit[33 +: AddressWidth] == ADDR);
  assign o_data = o_data_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      o_drop_count <= '0;
    end else begin
      if (accept) rr <= (win == RW'(numPE-1)) ? '0 : win + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (accept && !push && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= flit;
`ifdef FC_EGRESS_LATENCY_EN
  logic [31:0] cycle_counter;
  always_ff @(posedge clk or posedge rst)
    if (rst) cycle_counter <= '0;
    else cycle_counter <= cycle_counter + 1'b1;
  assign o_latency = o_data_valid ? cycle_counter - o_data[31:0] : '0;
`endif
endmodule

// File: tb/tb_fc_egress_port.sv
// tb_fc_egress_port: directed and randomized checks of fc_egress_port against a queue-based reference model.
`timescale 1ns/1ps
module tb_fc_egress_port;
  localparam int N = 8;
  localparam int ADDR = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*38-1:0] i_data = '0;
  logic [N-1:0] i_data_valid = '0;
  logic [N-1:0] o_data_ready;
  logic [37:0] o_data;
  logic o_data_valid;
  logic i_data_ready = 1'b0;
  logic [15:0] o_drop_count;
  int nvec = 0;
  int nerr = 0;
  logic [37:0] mq[$];
  int m_rr = 0;
  int m_drop = 0;
`ifdef FC_EGRESS_LATENCY_EN
  logic [31:0] o_latency;
  logic [31:0] tcyc;
  always @(posedge clk or posedge rst)
    if (rst) tcyc <= 0;
    else tcyc <= tcyc + 1;
`endif

  fc_egress_port #(.address(ADDR), .AddressWidth(3), .numPE(N), .FifoDepth(4)) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .o_data(o_data),
    .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready),
`ifdef FC_EGRESS_LATENCY_EN
    .o_latency(o_latency),
`endif
    .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input logic [2:0] dest, input logic [31:0] pl);
    return {2'b11, dest, 1'b0, pl};
  endfunction

  // Expected winner: first valid lane scanning from the rr pointer, if the FIFO can take it.
  function automatic int calc_grant();
    bit space;
    space = mq.size() < 4 || (mq.size() != 0 && i_data_ready);
    if (!space || rst) return -1;
    for (int i = 0; i < N; i++)
      if (i_data_valid[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = calc_grant();
    return g < 0 ? '0 : N'(1) << g;
  endfunction

  function automatic logic [37:0] exp_data();
    return mq.size() != 0 ? mq[0] : '0;
  endfunction

  task automatic tick(output int g);
    logic [37:0] f;
    bit pop;
    g = calc_grant();
    pop = mq.size() != 0 && i_data_ready;
    f = '0;
    if (g >= 0) f = i_data[g*38 +: 38];
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      if (f[35:33] == 3'(ADDR)) mq.push_back(f);
      else if (m_drop < 65535) m_drop++;
      m_rr = (g + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_data_valid = '0;
    i_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_rr = 0;
    m_drop = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_data = {N{mk(3'(ADDR), 32'h55)}};
    i_data_valid = '1;
    i_data_ready = 1'b1;
    @(posedge clk);
    #1;
    nvec++; if (o_data_ready !== '0) begin nerr++; $display("FAIL reset_ready: got %b want 0", o_data_ready); end
    nvec++; if (o_data_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", o_data_valid); end
    nvec++; if (o_data !== '0) begin nerr++; $display("FAIL reset_data: got %h want 0", o_data); end
    nvec++; if (o_drop_count !== 16'd0) begin nerr++; $display("FAIL reset_drop: got %0d want 0", o_drop_count); end
    do_reset();
  endtask

  task automatic test_single();
    int g;
    i_data_ready = 1'b1;
    i_data[2*38 +: 38] = mk(3'd5, 32'h10);
    i_data_valid = 8'b00000100;
    #1;
    nvec++; if (o_data_ready !== 8'b00000100) begin nerr++; $display("FAIL single_ready: got %b want 00000100", o_data_ready); end
    tick(g);
    i_data_valid = '0;
    #1;
    nvec++; if (o_data_ready !== '0) begin nerr++; $display("FAIL single_ready_off: got %b want 0", o_data_ready); end
    nvec++; if (o_data_valid !== 1'b1 || o_data !== mk(3'd5, 32'h10)) begin nerr++; $display("FAIL single_deliver: got %b/%h want 1/%h", o_data_valid, o_data, mk(3'd5, 32'h10)); end
    tick(g);
    nvec++; if (o_data_valid !== 1'b0 || o_data !== '0) begin nerr++; $display("FAIL single_empty: got %b/%h want 0/0", o_data_valid, o_data); end
    nvec++; if (o_drop_count !== 16'd0) begin nerr++; $display("FAIL single_drop: got %0d want 0", o_drop_count); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    i_data_ready = 1'b1;
    for (int k = 0; k < N; k++) i_data[k*38 +: 38] = mk(3'(ADDR), 32'(k * 256));
    i_data_valid = '1;
    for (int c = 0; c < 17; c++) begin
      #1;
      nvec++; if (o_data_ready !== N'(1) << (c % N)) begin nerr++; $display("FAIL rr_grant c=%0d: got %b want lane %0d", c, o_data_ready, c % N); end
      nvec++; if (o_data_valid !== (mq.size() != 0) || o_data !== exp_data()) begin nerr++; $display("FAIL rr_deliver c=%0d: got %b/%h want %h", c, o_data_valid, o_data, exp_data()); end
      tick(g);
      if (g >= 0) i_data[g*38 +: 38] = mk(3'(ADDR), 32'(g * 256 + c + 1));
    end
  endtask

  task automatic test_backpressure();
    int g;
    do_reset();
    i_data_ready = 1'b0;
    i_data[0 +: 38] = mk(3'(ADDR), 32'hB000);
    i_data[38 +: 38] = mk(3'(ADDR), 32'hB001);
    i_data_valid = 8'b00000011;
    for (int c = 0; c < 16; c++) begin
      if (c == 6) i_data_ready = 1'b1;
      #1;
      if (c == 5) begin
        nvec++; if (o_data_ready !== '0) begin nerr++; $display("FAIL bp_full: got %b want 0", o_data_ready); end
      end
      nvec++; if (o_data_ready !== exp_ready()) begin nerr++; $display("FAIL bp_ready c=%0d: got %b want %b", c, o_data_ready, exp_ready()); end
      nvec++; if (o_data_valid !== (mq.size() != 0) || o_data !== exp_data()) begin nerr++; $display("FAIL bp_deliver c=%0d: got %b/%h want %h", c, o_data_valid, o_data, exp_data()); end
      tick(g);
      if (g >= 0) i_data[g*38 +: 38] = mk(3'(ADDR), 32'hB100 + 32'(c * 2 + g));
    end
  endtask

  task automatic test_drop();
    int g;
    do_reset();
    i_data_ready = 1'b1;
    i_data[6*38 +: 38] = mk(3'd3, 32'h66);
    i_data_valid = 8'b01000000;
    #1;
    nvec++; if (o_data_ready !== 8'b01000000) begin nerr++; $display("FAIL drop_ready: got %b want 01000000", o_data_ready); end
    tick(g);
    i_data_valid = '0;
    #1;
    nvec++; if (o_data_valid !== 1'b0) begin nerr++; $display("FAIL drop_valid: got %b want 0", o_data_valid); end
    nvec++; if (o_drop_count !== 16'd1) begin nerr++; $display("FAIL drop_count: got %0d want 1", o_drop_count); end
  endtask

  task automatic test_saturation();
    i_data = {N{mk(3'd3, 32'h77)}};
    i_data_valid = '1;
    repeat (65533) @(posedge clk);
    #1;
    nvec++; if (o_drop_count !== 16'hFFFE) begin nerr++; $display("FAIL sat_near: got %h want fffe", o_drop_count); end
    repeat (4467) @(posedge clk);
    #1;
    nvec++; if (o_drop_count !== 16'hFFFF) begin nerr++; $display("FAIL sat_final: got %h want ffff", o_drop_count); end
    nvec++; if (o_data_valid !== 1'b0) begin nerr++; $display("FAIL sat_valid: got %b want 0", o_data_valid); end
    do_reset();
  endtask

  task automatic test_reset_midstream();
    int g;
    do_reset();
    i_data_ready = 1'b0;
    i_data_valid = 8'b00001000;
    for (int c = 0; c < 3; c++) begin
      i_data[3*38 +: 38] = mk(3'(ADDR), 32'hC00 + 32'(c));
      tick(g);
    end
    i_data[0 +: 38] = mk(3'(ADDR), 32'hD0);
    i_data[5*38 +: 38] = mk(3'(ADDR), 32'hD5);
    i_data_valid = 8'b00100001;
    #1;
    nvec++; if (o_data_ready !== 8'b00100000 || o_data !== exp_data()) begin nerr++; $display("FAIL mid_pre: got %b/%h want 00100000/%h", o_data_ready, o_data, exp_data()); end
    rst = 1'b1;
    #1;
    nvec++; if (o_data_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid: got %b want 0", o_data_valid); end
    nvec++; if (o_data !== '0) begin nerr++; $display("FAIL mid_data: got %h want 0", o_data); end
    nvec++; if (o_data_ready !== '0) begin nerr++; $display("FAIL mid_ready: got %b want 0", o_data_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_rr = 0;
    m_drop = 0;
    #1;
    nvec++; if (o_data_ready !== 8'b00000001) begin nerr++; $display("FAIL mid_restart: got %b want 00000001", o_data_ready); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++)
        if (!i_data_valid[k] && $urandom_range(0, 1) == 1) begin
          i_data[k*38 +: 38] = mk($urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : 3'(ADDR), $urandom());
          i_data_valid[k] = 1'b1;
        end
      i_data_ready = c < 300 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      #1;
      nvec++; if (o_data_ready !== exp_ready()) begin nerr++; $display("FAIL rand_ready c=%0d: got %b want %b", c, o_data_ready, exp_ready()); end
      nvec++; if (o_data_valid !== (mq.size() != 0)) begin nerr++; $display("FAIL rand_valid c=%0d: got %b want %b", c, o_data_valid, mq.size() != 0); end
      nvec++; if (o_data !== exp_data()) begin nerr++; $display("FAIL rand_data c=%0d: got %h want %h", c, o_data, exp_data()); end
      nvec++; if (o_drop_count !== 16'(m_drop)) begin nerr++; $display("FAIL rand_drop c=%0d: got %0d want %0d", c, o_drop_count, m_drop); end
      tick(g);
      if (g >= 0) i_data_valid[g] = 1'b0;
    end
  endtask

`ifdef FC_EGRESS_LATENCY_EN
  task automatic test_latency();
    int g;
    int t;
    do_reset();
    i_data_ready = 1'b1;
    t = 0;
    while (tcyc != 106 && t < 200) begin @(posedge clk); #1; t++; end
    nvec++; if (tcyc !== 32'd106) begin nerr++; $display("FAIL lat_wait: got %0d want 106", tcyc); end
    i_data[0 +: 38] = mk(3'(ADDR), 32'd100);
    i_data_valid = 8'b00000001;
    tick(g);
    i_data_valid = '0;
    #1;
    nvec++; if (o_latency !== 32'd7) begin nerr++; $display("FAIL lat_basic: got %0d want 7", o_latency); end
    tick(g);
    nvec++; if (o_latency !== 32'd0) begin nerr++; $display("FAIL lat_empty: got %0d want 0", o_latency); end
    do_reset();
    t = 0;
    while (tcyc != 2 && t < 200) begin @(posedge clk); #1; t++; end
    i_data[0 +: 38] = mk(3'(ADDR), 32'hFFFFFFFE);
    i_data_valid = 8'b00000001;
    tick(g);
    i_data_valid = '0;
    #1;
    nvec++; if (o_latency !== 32'd5) begin nerr++; $display("FAIL lat_wrap: got %0d want 5", o_latency); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_saturation();
    test_reset_midstream();
    test_random();
`ifdef FC_EGRESS_LATENCY_EN
    test_latency();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
